// File: rtl/clock_divider_core.sv
// Integer clock divider: a wrap-around counter feeds a registered, glitch-free clock_out.
// Optional one-cycle wrap pulse on port tick when CLOCK_DIVIDER_TICK_EN is defined.
module clock_divider_core #(
  parameter logic [27:0] DIVISOR = 28'd2
) (
  input  logic        clock_in,
  input  logic        rst,
  input  logic        enable,
  output logic        clock_out,
  output logic [27:0] count
`ifdef CLOCK_DIVIDER_TICK_EN
  ,
  output logic        tick
`endif
);

  localparam logic [27:0] HALF = DIVISOR >> 1;
  localparam logic [27:0] LAST = DIVISOR - 28'd1;

  generate
    if (DIVISOR < 28'd2) begin : g_bad_divisor
      $error("clock_divider_core: DIVISOR must be at least 2");
    end
  endgenerate

  logic [27:0] count_q, count_d;
  logic        clock_out_q, clock_out_d;

  always_comb begin
    count_d = count_q;
    if (enable) begin
      count_d = (count_q == LAST) ? 28'd0 : count_q + 28'd1;
    end
    // Deriving from the next count keeps clock_out == (count >= DIVISOR/2) every cycle.
    clock_out_d = (count_d >= HALF);
  end

  always_ff @(posedge clock_in) begin
    if (rst) begin
      count_q     <= 28'd0;
      clock_out_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      clock_out_q <= clock_out_d;
    end
  end

  assign count     = count_q;
  assign clock_out = clock_out_q;

`ifdef CLOCK_DIVIDER_TICK_EN
  logic tick_q, tick_d;

  always_comb begin
    tick_d = enable && (count_q == LAST);
  end

  always_ff @(posedge clock_in) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
`endif

endmodule

// File: tb/tb_clock_divider_core.sv
// Drives four dividers (DIVISOR 2, 4, 5, 7) from shared stimulus and compares each
// against an arithmetic reference model every cycle.
module tb_clock_divider_core;

  localparam int NDUT = 4;
  localparam logic [NDUT-1:0][27:0] DIVS = {28'd7, 28'd5, 28'd4, 28'd2};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;

  logic [NDUT-1:0]       clk_out_w;
  logic [NDUT-1:0][27:0] count_w;
`ifdef CLOCK_DIVIDER_TICK_EN
  logic [NDUT-1:0]       tick_w;
`endif

  int checks = 0;
  int failures = 0;

  int unsigned m_cnt [NDUT];
  bit          m_tick[NDUT];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
    clock_divider_core #(.DIVISOR(DIVS[gi])) u_dut (
      .clock_in (clk),
      .rst      (rst),
      .enable   (enable),
      .clock_out(clk_out_w[gi]),
      .count    (count_w[gi])
`ifdef CLOCK_DIVIDER_TICK_EN
      ,
      .tick     (tick_w[gi])
`endif
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock edge: apply inputs, advance the model, then compare all instances.
  task automatic step(input bit en, input bit r);
    @(negedge clk);
    rst = r;
    enable = en;
    @(posedge clk);
    for (int i = 0; i < NDUT; i++) begin
      int unsigned d;
      d = int'(DIVS[i]);
      m_tick[i] = !r && en && (m_cnt[i] == d - 1);
      if (r) m_cnt[i] = 0;
      else if (en) m_cnt[i] = (m_cnt[i] + 1) % d;
    end
    #1;
    for (int i = 0; i < NDUT; i++) begin
      int unsigned d;
      d = int'(DIVS[i]);
      check($sformatf("d%0d_count", d), 32'(count_w[i]), m_cnt[i]);
      check($sformatf("d%0d_clkout", d), 32'(clk_out_w[i]), 32'(m_cnt[i] >= d / 2));
`ifdef CLOCK_DIVIDER_TICK_EN
      check($sformatf("d%0d_tick", d), 32'(tick_w[i]), 32'(m_tick[i]));
`endif
    end
    $display("step rst=%0d en=%0d counts=%0d/%0d/%0d/%0d clk_out=%b",
             r, en, count_w[0], count_w[1], count_w[2], count_w[3], clk_out_w);
  endtask

  initial begin
    for (int i = 0; i < NDUT; i++) begin
      m_cnt[i]  = 0;
      m_tick[i] = 1'b0;
    end

    // Reset for two cycles, enable high so reset priority is exercised.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    check("d4_reset_count", 32'(count_w[1]), 32'd0);
    check("d4_reset_clkout", 32'(clk_out_w[1]), 32'd0);

    // Two enabled edges bring DIVISOR=4 to count 2, clock_out high.
    step(1'b1, 1'b0);
    check("d2_first_edge_high", 32'(clk_out_w[0]), 32'd1);
    step(1'b1, 1'b0);
    check("d4_count_at_2", 32'(count_w[1]), 32'd2);

    // Freeze for three cycles mid-phase.
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0);
      check("d4_hold_count", 32'(count_w[1]), 32'd2);
      check("d4_hold_clkout", 32'(clk_out_w[1]), 32'd1);
    end
    step(1'b1, 1'b0);
    check("d4_resume_count", 32'(count_w[1]), 32'd3);
    step(1'b1, 1'b0);
    check("d4_wrap_count", 32'(count_w[1]), 32'd0);
    check("d4_wrap_clkout", 32'(clk_out_w[1]), 32'd0);

    // Run DIVISOR=4 up to count 3, then reset mid-period with enable still high.
    for (int k = 0; k < 8 && m_cnt[1] != 3; k++) step(1'b1, 1'b0);
    check("d4_before_rst", 32'(count_w[1]), 32'd3);
    step(1'b1, 1'b1);
    check("d4_midrst_count", 32'(count_w[1]), 32'd0);
    check("d4_midrst_clkout", 32'(clk_out_w[1]), 32'd0);

    // Long enabled run covering several full periods of every divisor.
    for (int k = 0; k < 40; k++) begin
      step(1'b1, 1'b0);
      check("d5_range", 32'(count_w[2] <= 28'd4), 32'd1);
    end

    // Randomized enable with occasional resets.
    for (int k = 0; k < 600; k++) begin
      step($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
